// File: rtl/arp_pkg.sv
// Shared ARP constants, frame geometry and the reply FSM state type.
// Frame geometry depends on ARP_TX_ETH_HDR_EN. When it is defined, a 14-byte Ethernet header is prepended.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4  = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY  = 16'h0002;
  localparam logic [15:0] ETHERTYPE_ARP   = 16'h0806;
  localparam int          ARP_PAYLOAD_LEN = 28;
  localparam int          ETH_HDR_LEN     = 14;

`ifdef ARP_TX_ETH_HDR_EN
  localparam int FRAME_LEN = ETH_HDR_LEN + ARP_PAYLOAD_LEN;
`else
  localparam int FRAME_LEN = ARP_PAYLOAD_LEN;
`endif

  // Index of the final byte of a frame; the 6-bit counter stops here.
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } arp_state_e;

  // Byte k (0 = most significant) of a 48-bit MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] v, input logic [2:0] k);
    logic [47:0] t;
    t = v >> (6'd40 - {k, 3'b000});
    return t[7:0];
  endfunction

  // Byte k (0 = most significant) of a 32-bit IPv4 address.
  function automatic logic [7:0] ip_byte(input logic [31:0] v, input logic [1:0] k);
    logic [31:0] t;
    t = v >> (5'd24 - {k, 3'b000});
    return t[7:0];
  endfunction

endpackage

// File: rtl/arp_byte_mux.sv
// Combinational selection of one reply-frame byte from the byte index and latched request fields.
// When ARP_TX_ETH_HDR_EN is defined, indices 0..13 carry the Ethernet header: dst = sha, src = MY_MAC, type 0806.
module arp_byte_mux
  import arp_pkg::*;
#(
  parameter logic [31:0] MY_IP  = 32'hC0A8000A,
  parameter logic [47:0] MY_MAC = 48'h020000000001
) (
  input  logic [5:0]  idx,
  input  logic [31:0] spa,
  input  logic [47:0] sha,
  output logic [7:0]  byte_out
);

  logic [5:0] p;
  logic       hdr_hit;

  // Map the frame index to a header byte or an ARP payload byte.
  always_comb begin
    byte_out = 8'h00;
    p        = idx;
    hdr_hit  = 1'b0;
`ifdef ARP_TX_ETH_HDR_EN
    p = idx - 6'(ETH_HDR_LEN);
    if (idx < 6'd6) begin
      hdr_hit  = 1'b1;
      byte_out = mac_byte(sha, idx[2:0]);
    end else if (idx < 6'd12) begin
      hdr_hit  = 1'b1;
      byte_out = mac_byte(MY_MAC, 3'(idx - 6'd6));
    end else if (idx == 6'd12) begin
      hdr_hit  = 1'b1;
      byte_out = ETHERTYPE_ARP[15:8];
    end else if (idx == 6'd13) begin
      hdr_hit  = 1'b1;
      byte_out = ETHERTYPE_ARP[7:0];
    end
`endif
    if (!hdr_hit) begin
      if (p < 6'd8) begin
        case (p[2:0])
          3'd0:    byte_out = ARP_HTYPE_ETH[15:8];
          3'd1:    byte_out = ARP_HTYPE_ETH[7:0];
          3'd2:    byte_out = ARP_PTYPE_IPV4[15:8];
          3'd3:    byte_out = ARP_PTYPE_IPV4[7:0];
          3'd4:    byte_out = 8'd6;   // HLEN
          3'd5:    byte_out = 8'd4;   // PLEN
          3'd6:    byte_out = ARP_OPER_REPLY[15:8];
          default: byte_out = ARP_OPER_REPLY[7:0];
        endcase
      end else if (p < 6'd14) begin
        byte_out = mac_byte(MY_MAC, 3'(p - 6'd8));
      end else if (p < 6'd18) begin
        byte_out = ip_byte(MY_IP, 2'(p - 6'd14));
      end else if (p < 6'd24) begin
        byte_out = mac_byte(sha, 3'(p - 6'd18));
      end else if (p < 6'd28) begin
        byte_out = ip_byte(spa, 2'(p - 6'd24));
      end
    end
  end

endmodule

// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: on a request for MY_IP, streams an opcode-2 reply byte-serially.
// Build option ARP_TX_ETH_HDR_EN prepends a 14-byte Ethernet header (42 bytes instead of 28).
// Stream handshake: a byte moves on a rising edge where tx_valid & tx_ready; while tx_valid=1 and
// tx_ready=0, tx_data/tx_valid/tx_last hold; the next byte is presented the cycle after a transfer.
module arp_reply_tx
  import arp_pkg::*;
#(
  parameter logic [31:0] MY_IP  = 32'hC0A8000A,
  parameter logic [47:0] MY_MAC = 48'h020000000001
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        req_valid,
  input  logic [31:0] req_spa,
  input  logic [47:0] req_sha,
  input  logic [31:0] req_tpa,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  state_dbg
);

  arp_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] spa_q, spa_d;
  logic [47:0] sha_q, sha_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  mux_byte;

  arp_byte_mux #(
    .MY_IP  (MY_IP),
    .MY_MAC (MY_MAC)
  ) u_mux (
    .idx      (cnt_q),
    .spa      (spa_q),
    .sha      (sha_q),
    .byte_out (mux_byte)
  );

  // State, counter, latched fields and drop counter; aclr clears everything at once.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      spa_q   <= 32'd0;
      sha_q   <= 48'd0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spa_q   <= spa_d;
      sha_q   <= sha_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, field capture, byte advance and drop accounting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spa_d   = spa_q;
    sha_d   = sha_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (req_tpa == MY_IP)) begin
          state_d = LOAD;
          spa_d   = req_spa;   // captured on the request edge so later input changes are ignored
          sha_d   = req_sha;
        end
      end
      LOAD: begin
        cnt_d   = 6'd0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (cnt_q == LAST_IDX) state_d = IDLE;
          else                   cnt_d   = cnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Any request that does not start a reply is counted, including one on the last-byte edge.
    if (req_valid && ((state_q != IDLE) || (req_tpa != MY_IP)) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  // Outputs decode directly from state so aclr removes tx_valid without waiting for a clock.
  always_comb begin
    busy      = (state_q != IDLE);
    tx_valid  = (state_q == SEND);
    tx_last   = tx_valid && (cnt_q == LAST_IDX);
    tx_data   = tx_valid ? mux_byte : 8'h00;
    drop_cnt  = drop_q;
    state_dbg = state_q;
  end

endmodule
